// File: rtl/simple_arch_pkg.sv
// Shared definitions for the 16-bit simple architecture: instruction field
// codes, flag layout, sequencer phases and the instruction classifier.
package simple_arch_pkg;

  // Instruction classes, IR[15:14]
  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_CTL = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  // Control-class sub-operations, IR[13:11]
  localparam logic [2:0] SUB_LI  = 3'b000;
  localparam logic [2:0] SUB_B   = 3'b100;
  localparam logic [2:0] SUB_BCC = 3'b111;

  // Branch condition codes, IR[10:8]
  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  // ALU selects
  localparam logic [3:0] ALU_NOP = 4'b1111;
  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Flag bit positions in {S,Z,C,V}
  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_ERR
  } phase_e;

  typedef struct packed {
    logic       alu;
    logic       ld;
    logic       st;
    logic       li;
    logic       br;
    logic       bcc;
    logic       hlt;
    logic       illegal;
    logic [2:0] rd;
    logic [3:0] op;
    logic [2:0] cond;
  } dec_t;

  // Classify IR[15:4] (the low nibble carries no sequencing information)
  function automatic dec_t decode_ir(input logic [11:0] w);
    dec_t d;
    d      = '0;
    d.op   = w[3:0];
    d.cond = w[6:4];
    case (w[11:10])
      CLS_ALU: begin
        if (w[3:0] == ALU_NOP) begin
          d.hlt = 1'b1;
        end else begin
          d.alu = 1'b1;
          d.rd  = w[6:4];
        end
      end
      CLS_LD: begin
        d.ld = 1'b1;
        d.rd = w[9:7];
      end
      CLS_ST: d.st = 1'b1;
      default: begin
        case (w[9:7])
          SUB_LI: begin
            d.li = 1'b1;
            d.rd = w[6:4];
          end
          SUB_B:   d.br = 1'b1;
          SUB_BCC: begin
            if (w[6]) d.illegal = 1'b1;
            else      d.bcc     = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Main-memory handshake between the phase sequencer (master) and memory (slave).
interface phase_sequencer_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        ADDR_SEL;
  logic        MEM_ACK;
  logic [15:0] IR_IN;

  modport master (
    output MEM_REQ, MEM_WE, ADDR_SEL,
    input  MEM_ACK, IR_IN
  );

  modport slave (
    input  MEM_REQ, MEM_WE, ADDR_SEL,
    output MEM_ACK, IR_IN
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Branch decision from the latched flag register.
module branch_cond_eval
  import simple_arch_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [3:0] flags_i,
  input  logic       uncond_i,
  output logic       taken_o
);

  logic lt;
  logic unused_carry;

  assign lt           = flags_i[FLAG_S] ^ flags_i[FLAG_V];
  assign unused_carry = flags_i[FLAG_C];

  // Unconditional branch always taken; otherwise evaluate the condition code
  always_comb begin
    taken_o = 1'b0;
    if (uncond_i) begin
      taken_o = 1'b1;
    end else begin
      case (cond_i)
        CC_BE:   taken_o = flags_i[FLAG_Z];
        CC_BLT:  taken_o = lt;
        CC_BLE:  taken_o = flags_i[FLAG_Z] | lt;
        CC_BNE:  taken_o = ~flags_i[FLAG_Z];
        default: taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: fetch, decode, execute, memory, write-back.
module phase_sequencer
  import simple_arch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     START,
  phase_sequencer_if.master        mem_bus,
  input  logic [3:0]               FLAGS,
  output logic                     PC_INC,
  output logic                     PC_LOAD,
  output logic                     REG_WE,
  output logic [2:0]               REG_WSEL,
  output logic [1:0]               WB_SEL,
  output logic [3:0]               S_ALU,
  output logic                     HALTED,
  output logic                     FAULT
);

  localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT_CYCLES - 1);

  phase_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flag_q, flag_d;
  logic [3:0]  wait_q, wait_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        addr_sel_q, addr_sel_d;
  logic        pc_inc_q, pc_inc_d;
  logic        pc_load_q, pc_load_d;
  logic        reg_we_q, reg_we_d;
  logic [2:0]  reg_wsel_q, reg_wsel_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [3:0]  s_alu_q, s_alu_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  dec_t        dec;
  logic        cond_taken;
  logic        taken;
  logic        wait_expired;
  logic        unused_ir_low;

  assign dec           = decode_ir(ir_q[15:4]);
  assign unused_ir_low = ^ir_q[3:0];
  assign wait_expired  = (wait_q == WAIT_LIMIT);
  assign taken         = (dec.br | dec.bcc) & cond_taken;

  branch_cond_eval u_branch_cond_eval (
    .cond_i   (dec.cond),
    .flags_i  (flag_q),
    .uncond_i (dec.br),
    .taken_o  (cond_taken)
  );

  // Phase register, instruction/flag latches and memory wait counter
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_HALT;
      ir_q    <= '0;
      flag_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      wait_q  <= wait_d;
    end
  end

  // Next phase: handshake completion, timeout, decode outcome
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    wait_d  = wait_q;
    case (state_q)
      ST_HALT: begin
        if (START) begin
          state_d = ST_P1;
          wait_d  = '0;
        end
      end
      ST_P1: begin
        if (mem_bus.MEM_ACK) begin
          ir_d    = mem_bus.IR_IN;
          state_d = ST_P2;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_P2: state_d = ST_P3;
      ST_P3: begin
        if (dec.hlt) begin
          state_d = ST_HALT;
        end else if (dec.illegal) begin
          state_d = ST_ERR;
        end else begin
          if (dec.alu) flag_d = FLAGS;
          state_d = ST_P4;
          wait_d  = '0;
        end
      end
      ST_P4: begin
        if (!(dec.ld || dec.st)) begin
          state_d = ST_P5;
        end else if (mem_bus.MEM_ACK) begin
          state_d = ST_P5;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_P5: begin
        state_d = ST_P1;
        wait_d  = '0;
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // Output values for the phase being entered; registering them alongside
  // state_q makes every output a clean function of the current phase.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    addr_sel_d = 1'b0;
    pc_inc_d   = 1'b0;
    pc_load_d  = 1'b0;
    reg_we_d   = 1'b0;
    reg_wsel_d = '0;
    wb_sel_d   = WB_ALU;
    s_alu_d    = ALU_NOP;
    halted_d   = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      ST_HALT: halted_d = 1'b1;
      ST_P1:   mem_req_d = 1'b1;
      ST_P2:   pc_inc_d  = 1'b1;
      ST_P3: begin
        if (dec.alu)              s_alu_d = dec.op;
        else if (dec.ld || dec.st) s_alu_d = ALU_ADD;
      end
      ST_P4: begin
        if (dec.ld || dec.st) begin
          mem_req_d  = 1'b1;
          addr_sel_d = 1'b1;
          mem_we_d   = dec.st;
        end
      end
      ST_P5: begin
        pc_load_d = taken;
        if (dec.alu || dec.ld || dec.li) begin
          reg_we_d   = 1'b1;
          reg_wsel_d = dec.rd;
          if (dec.ld)      wb_sel_d = WB_MEM;
          else if (dec.li) wb_sel_d = WB_IMM;
          else             wb_sel_d = WB_ALU;
        end
      end
      ST_ERR: begin
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end
      default: halted_d = 1'b1;
    endcase
  end

  // Output registers; reset clears strobes without waiting for a clock
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_wsel_q <= '0;
      wb_sel_q   <= WB_ALU;
      s_alu_q    <= ALU_NOP;
      halted_q   <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_sel_q <= addr_sel_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
      reg_we_q   <= reg_we_d;
      reg_wsel_q <= reg_wsel_d;
      wb_sel_q   <= wb_sel_d;
      s_alu_q    <= s_alu_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_bus.MEM_REQ  = mem_req_q;
  assign mem_bus.MEM_WE   = mem_we_q;
  assign mem_bus.ADDR_SEL = addr_sel_q;
  assign PC_INC           = pc_inc_q;
  assign PC_LOAD          = pc_load_q;
  assign REG_WE           = reg_we_q;
  assign REG_WSEL         = reg_wsel_q;
  assign WB_SEL           = wb_sel_q;
  assign S_ALU            = s_alu_q;
  assign HALTED           = halted_q;
  assign FAULT            = fault_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: reset, arithmetic, load wait states,
// branches, halt/illegal, fetch timeout and asynchronous reset mid-access.
module tb_phase_sequencer;
  import simple_arch_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] flags;
  logic       pc_inc;
  logic       pc_load;
  logic       reg_we;
  logic [2:0] reg_wsel;
  logic [1:0] wb_sel;
  logic [3:0] s_alu;
  logic       halted;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cycles;
    int unsigned req_cnt;
    int unsigned pc_inc_cnt;
    int unsigned pc_load_cnt;
    int unsigned reg_we_cnt;
    logic [3:0]  s_alu;
    logic        we;
    logic [2:0]  wsel;
    logic [1:0]  wbsel;
  } obs_t;

  phase_sequencer_if bus ();

  phase_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .START    (start),
    .mem_bus  (bus),
    .FLAGS    (flags),
    .PC_INC   (pc_inc),
    .PC_LOAD  (pc_load),
    .REG_WE   (reg_we),
    .REG_WSEL (reg_wsel),
    .WB_SEL   (wb_sel),
    .S_ALU    (s_alu),
    .HALTED   (halted),
    .FAULT    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst         = 1'b1;
    start       = 1'b0;
    bus.MEM_ACK = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from a P1 negedge (zero-wait fetch) until the next
  // fetch or a halted state; P4 memory acks after p4_wait wait cycles.
  task automatic exec_instr(input logic [15:0] w, input logic [3:0] fl,
                            input int unsigned p4_wait, output obs_t o);
    o.cycles      = 1;
    o.req_cnt     = 0;
    o.pc_inc_cnt  = 0;
    o.pc_load_cnt = 0;
    o.reg_we_cnt  = 0;
    o.s_alu       = ALU_NOP;
    o.we          = 1'b0;
    o.wsel        = '0;
    o.wbsel       = '0;
    bus.IR_IN     = w;
    bus.MEM_ACK   = 1'b1;
    flags         = fl;
    @(negedge clk);
    while (o.cycles < 40) begin
      bus.MEM_ACK = 1'b0;
      if ((bus.MEM_REQ && !bus.ADDR_SEL) || halted) break;
      o.cycles++;
      if (pc_inc)  o.pc_inc_cnt++;
      if (pc_load) o.pc_load_cnt++;
      if (s_alu !== ALU_NOP) o.s_alu = s_alu;
      if (bus.MEM_REQ && bus.ADDR_SEL) begin
        o.req_cnt++;
        o.we        = bus.MEM_WE;
        bus.MEM_ACK = (o.req_cnt == p4_wait + 1);
      end
      if (reg_we) begin
        o.reg_we_cnt++;
        o.wsel  = reg_wsel;
        o.wbsel = wb_sel;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.IR_IN = 16'hC520;
    flags     = 4'h0;
    do_reset();
    bus.MEM_ACK = 1'b1;
    repeat (10) @(negedge clk);
    bus.MEM_ACK = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %0b expected 1", halted); end
    checks++; if (s_alu !== 4'b1111) begin errors++; $display("FAIL reset_s_alu: got %b expected 1111", s_alu); end
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", bus.MEM_REQ); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
    checks++; if (dut.ir_q !== 16'h0000) begin errors++; $display("FAIL reset_ir_ack_ignored: got %h expected 0000", dut.ir_q); end
    checks++; if (dut.flag_q !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", dut.flag_q); end
    do_start();
    checks++; if (bus.MEM_REQ !== 1'b1) begin errors++; $display("FAIL start_mem_req: got %0b expected 1", bus.MEM_REQ); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL start_halted: got %0b expected 0", halted); end
  endtask

  task automatic test_alu();
    obs_t o;
    exec_instr(16'hC520, 4'h0, 0, o);
    checks++; if (o.cycles !== 5) begin errors++; $display("FAIL alu_cycles: got %0d expected 5", o.cycles); end
    checks++; if (o.s_alu !== 4'b0010) begin errors++; $display("FAIL alu_s_alu: got %b expected 0010", o.s_alu); end
    checks++; if (o.reg_we_cnt !== 1) begin errors++; $display("FAIL alu_reg_we: got %0d expected 1", o.reg_we_cnt); end
    checks++; if (o.wsel !== 3'd5) begin errors++; $display("FAIL alu_wsel: got %0d expected 5", o.wsel); end
    checks++; if (o.wbsel !== 2'b00) begin errors++; $display("FAIL alu_wbsel: got %b expected 00", o.wbsel); end
    checks++; if (o.pc_inc_cnt !== 1) begin errors++; $display("FAIL alu_pc_inc: got %0d expected 1", o.pc_inc_cnt); end
    checks++; if (o.req_cnt !== 0) begin errors++; $display("FAIL alu_p4_req: got %0d expected 0", o.req_cnt); end
    checks++; if (dut.state_q !== ST_P1) begin errors++; $display("FAIL alu_next_p1: got %0d expected %0d", dut.state_q, ST_P1); end
  endtask

  task automatic test_ld_wait();
    obs_t o;
    exec_instr(16'h2804, 4'h0, 3, o);
    checks++; if (o.cycles !== 8) begin errors++; $display("FAIL ld_cycles: got %0d expected 8", o.cycles); end
    checks++; if (o.req_cnt !== 4) begin errors++; $display("FAIL ld_req_cycles: got %0d expected 4", o.req_cnt); end
    checks++; if (o.we !== 1'b0) begin errors++; $display("FAIL ld_we: got %0b expected 0", o.we); end
    checks++; if (o.s_alu !== 4'b0000) begin errors++; $display("FAIL ld_s_alu: got %b expected 0000", o.s_alu); end
    checks++; if (o.wbsel !== 2'b01) begin errors++; $display("FAIL ld_wbsel: got %b expected 01", o.wbsel); end
    checks++; if (o.wsel !== 3'd5) begin errors++; $display("FAIL ld_wsel: got %0d expected 5", o.wsel); end
  endtask

  task automatic test_branch();
    obs_t o;
    exec_instr(16'hC110, 4'b1000, 0, o);
    checks++; if (dut.flag_q !== 4'b1000) begin errors++; $display("FAIL sub_flags: got %b expected 1000", dut.flag_q); end
    exec_instr(16'hB900, 4'b0000, 0, o);
    checks++; if (o.pc_load_cnt !== 1) begin errors++; $display("FAIL blt_taken: got %0d expected 1", o.pc_load_cnt); end
    checks++; if (o.reg_we_cnt !== 0) begin errors++; $display("FAIL blt_reg_we: got %0d expected 0", o.reg_we_cnt); end
    checks++; if (o.cycles !== 5) begin errors++; $display("FAIL blt_cycles: got %0d expected 5", o.cycles); end
    checks++; if (dut.flag_q !== 4'b1000) begin errors++; $display("FAIL blt_flags_kept: got %b expected 1000", dut.flag_q); end
    exec_instr(16'hC110, 4'b0000, 0, o);
    exec_instr(16'hB800, 4'b0100, 0, o);
    checks++; if (o.pc_load_cnt !== 0) begin errors++; $display("FAIL be_not_taken: got %0d expected 0", o.pc_load_cnt); end
    exec_instr(16'hA000, 4'b0000, 0, o);
    checks++; if (o.pc_load_cnt !== 1) begin errors++; $display("FAIL b_taken: got %0d expected 1", o.pc_load_cnt); end
    exec_instr(16'h8300, 4'b0000, 0, o);
    checks++; if (o.wbsel !== 2'b10) begin errors++; $display("FAIL li_wbsel: got %b expected 10", o.wbsel); end
    checks++; if (o.wsel !== 3'd3) begin errors++; $display("FAIL li_wsel: got %0d expected 3", o.wsel); end
    checks++; if (o.pc_load_cnt !== 0) begin errors++; $display("FAIL li_pc_load: got %0d expected 0", o.pc_load_cnt); end
  endtask

  task automatic test_hlt_illegal();
    obs_t o;
    exec_instr(16'hC0F0, 4'h0, 0, o);
    checks++; if (o.cycles !== 3) begin errors++; $display("FAIL hlt_cycles: got %0d expected 3", o.cycles); end
    checks++; if (dut.state_q !== ST_HALT) begin errors++; $display("FAIL hlt_state: got %0d expected %0d", dut.state_q, ST_HALT); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL hlt_fault: got %0b expected 0", fault); end
    do_start();
    exec_instr(16'hBC00, 4'h0, 0, o);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault: got %0b expected 1", fault); end
    checks++; if (dut.state_q !== ST_ERR) begin errors++; $display("FAIL illegal_state: got %0d expected %0d", dut.state_q, ST_ERR); end
  endtask

  task automatic test_timeout();
    int unsigned k;
    do_reset();
    do_start();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.MEM_REQ) break;
      k++;
      @(negedge clk);
    end
    checks++; if (k !== 15) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 15", k); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %0b expected 1", fault); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL timeout_halted: got %0b expected 1", halted); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL err_start_req: got %0b expected 0", bus.MEM_REQ); end
    checks++; if (dut.state_q !== ST_ERR) begin errors++; $display("FAIL err_start_state: got %0d expected %0d", dut.state_q, ST_ERR); end
    do_reset();
    do_start();
    repeat (14) @(negedge clk);
    checks++; if (bus.MEM_REQ !== 1'b1) begin errors++; $display("FAIL ack15_req: got %0b expected 1", bus.MEM_REQ); end
    bus.IR_IN   = 16'hC520;
    bus.MEM_ACK = 1'b1;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    checks++; if (dut.state_q !== ST_P2) begin errors++; $display("FAIL ack15_state: got %0d expected %0d", dut.state_q, ST_P2); end
    checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL ack15_pc_inc: got %0b expected 1", pc_inc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ack15_fault: got %0b expected 0", fault); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    do_start();
    exec_instr(16'hC110, 4'hF, 0, o);
    checks++; if (dut.flag_q !== 4'hF) begin errors++; $display("FAIL mid_flags_set: got %h expected f", dut.flag_q); end
    bus.IR_IN   = 16'h4000;
    bus.MEM_ACK = 1'b1;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.MEM_REQ, bus.MEM_WE, bus.ADDR_SEL} !== 3'b111) begin errors++; $display("FAIL st_p4_strobes: got %b expected 111", {bus.MEM_REQ, bus.MEM_WE, bus.ADDR_SEL}); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %0b expected 0", bus.MEM_REQ); end
    checks++; if (bus.MEM_WE !== 1'b0) begin errors++; $display("FAIL mid_reset_we: got %0b expected 0", bus.MEM_WE); end
    checks++; if (dut.state_q !== ST_HALT) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_q, ST_HALT); end
    checks++; if (dut.flag_q !== 4'h0) begin errors++; $display("FAIL mid_reset_flags: got %h expected 0", dut.flag_q); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mid_reset_halted: got %0b expected 1", halted); end
    @(negedge clk);
    checks++; if ({pc_inc, pc_load, reg_we} !== 3'b000) begin errors++; $display("FAIL mid_reset_pulses: got %b expected 000", {pc_inc, pc_load, reg_we}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    flags       = 4'h0;
    bus.MEM_ACK = 1'b0;
    bus.IR_IN   = 16'h0000;
    test_reset();
    test_alu();
    test_ld_wait();
    test_branch();
    test_hlt_illegal();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit simple architecture.
- Steps each instruction through five phases: P1 fetch, P2 decode, P3 execute, P4 memory, P5 write-back.
- Drives the ALU select, the memory handshake, PC control and register write-back, and decides conditional branches from the latched ALU flags.
- Sits between the main-memory interface and the register/ALU datapath; the instruction decoder is internal.

Parameters:
- TIMEOUT_CYCLES, 15, maximum number of cycles MEM_REQ may wait for MEM_ACK before FAULT (4-bit counter; legal range 1..15).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  leave HALT and begin fetching; ignored in any other state.
- IR_IN  in  16  instruction word from memory, valid when MEM_ACK=1 in P1.
- MEM_ACK  in  1  memory completion, sampled on the rising edge.
- FLAGS  in  4  ALU flags {S,Z,C,V}, valid in P3.
- MEM_REQ  out  1  memory request, held until acknowledged.
- MEM_WE  out  1  1 = store; valid while MEM_REQ=1.
- ADDR_SEL  out  1  0 = address from PC, 1 = address from ALU result.
- PC_INC  out  1  one-cycle pulse: PC <= PC+1.
- PC_LOAD  out  1  one-cycle pulse: PC <= branch target.
- REG_WE  out  1  register-file write enable (P5 only).
- REG_WSEL  out  3  destination register number.
- WB_SEL  out  2  write-back source: 00 = ALU, 01 = memory, 10 = immediate.
- S_ALU  out  4  ALU operation select; 4'b1111 = no operation.
- HALTED  out  1  1 in HALT.
- FAULT  out  1  sticky; set on timeout or illegal opcode.

Behaviour:
- Reset (asynchronous, active-high):
  - state = HALT, HALTED = 1, S_ALU = 4'b1111.
  - All other outputs 0; IR = 0; flag register = 0; FAULT = 0.
- States: HALT, P1, P2, P3, P4, P5, ERR.
- Outputs are registered unless stated otherwise.
- HALT:
  - START = 1 -> P1 on the next edge.
- P1 (fetch):
  - MEM_REQ = 1, MEM_WE = 0, ADDR_SEL = 0.
  - On an edge with MEM_ACK = 1: IR <= IR_IN, PC_INC pulses in the following cycle, go to P2.
  - Zero-wait memory gives a 1-cycle P1.
- P2 (decode):
  - Classify IR[15:14]:
    - 11: arithmetic. S_ALU = IR[7:4], rd = IR[10:8].
    - 00: LD. rd = IR[13:11].
    - 01: ST.
    - 10: IR[13:11] selects 000 = LI, 100 = B, 111 = conditional branch with condition IR[10:8].
  - Arithmetic with IR[7:4] = 4'b1111 is HLT.
  - Class 10 with any other sub-op, or a condition code >= 3'b100, is illegal.
- P3 (execute):
  - S_ALU driven for arithmetic, LD and ST (LD/ST use 4'b0000 for address add); 4'b1111 otherwise.
  - Arithmetic latches FLAGS into the internal flag register at the end of P3; no other class changes it.
  - HLT -> HALT; illegal -> ERR; all others -> P4.
- P4 (memory):
  - LD/ST assert MEM_REQ with ADDR_SEL = 1 and MEM_WE = (class == 01), using the same wait rule as P1.
  - Other classes spend exactly one cycle in P4 with no request.
- Branch decision (at P4 exit, from the flag register):
  - B: always taken.
  - BE (000): Z.
  - BLT (001): S^V.
  - BLE (010): Z | (S^V).
  - BNE (011): ~Z.
  - Taken: PC_LOAD pulses for one cycle in P5.
- P5 (write-back):
  - REG_WE = 1 for arithmetic, LD and LI; WB_SEL = 00, 01 or 10 respectively; REG_WSEL = rd.
  - Next state is P1.
- Wait counter:
  - Clears on entry to P1 or P4 and increments every cycle MEM_REQ = 1 without MEM_ACK.
  - At count == TIMEOUT_CYCLES: go to ERR, drop MEM_REQ.
  - MEM_ACK in the same cycle the limit is reached wins: the access completes.
- ERR:
  - FAULT = 1, HALTED = 1, all strobes 0.
  - Exit only by RESET; START is ignored.
- Latency: minimum 5 cycles per instruction; each memory wait cycle adds 1.
- Reset mid-operation:
  - MEM_REQ and REG_WE drop immediately (asynchronous).
  - No pulse of PC_INC or PC_LOAD completes.
- START asserted while not in HALT has no effect.
- MEM_ACK arriving outside P1/P4 request cycles is ignored.

Decomposition:
- Package simple_arch_pkg holds:
  - Class codes (2'b00 LD, 2'b01 ST, 2'b10 control, 2'b11 ALU) and the control sub-ops (LI, B, BCC).
  - Condition codes (BE, BLT, BLE, BNE) and the ALU no-op constant 4'b1111.
  - Flag bit indices and the state enumeration.
- One combinational sub-module, branch_cond_eval: inputs are the condition code, the flags and a branch-class bit; output is taken.

Test Plan:
- Reset, then no START for 10 cycles -> HALTED = 1, S_ALU = 4'b1111, MEM_REQ = 0. START -> MEM_REQ = 1 on the next cycle.
- Arithmetic word 16'hC520 (class 11, rs 0, rd 5, op 4'b0010), zero-wait memory:
  - 5 cycles total.
  - S_ALU = 4'b0010 in P3.
  - P5: REG_WE = 1, REG_WSEL = 5, WB_SEL = 00.
  - Then P1 again.
- LD (16'h2804) with MEM_ACK delayed 3 cycles in P4 -> MEM_REQ held 4 cycles, ADDR_SEL = 1, MEM_WE = 0; instruction takes 8 cycles; WB_SEL = 01.
- Preceding SUB leaves flags S = 1, V = 0; then BLT (16'hB900) -> PC_LOAD pulses once. Same with Z = 0 and BE -> no PC_LOAD.
- Memory never acks in P1 with TIMEOUT_CYCLES = 15 -> ERR after 15 wait cycles, FAULT = 1, MEM_REQ = 0, START ignored. Ack in cycle 15 -> normal completion.
- RESET asserted mid-P4 of an ST -> MEM_REQ and MEM_WE fall without waiting for a clock edge, state = HALT, flag register = 0.
